fetch_unit: RTL and testbench

//  Front-end fetch stage of the OOO core; sits directly upstream of instructionMemory.
//  - Owns the PC and drives pc_addr.
//  - Captures the CORE_WIDTH-wide instruction_blk returned combinationally by memory.
//  - Buffers fetched packets in a small fetch queue; hands them to decode via valid/ready.
//  - Flushes the queue and re-steers the PC on a backend redirect (branch mispredict/exception).

---
 rtl/fetch_unit.sv | 109 ++++++++++
 tb/tb_fetch_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch stage: PC owner, fetch queue, redirect handling
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_stall_full counters.
module fetch_unit #(
  parameter int          CORE_WIDTH = 2,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          FQ_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic [31:0]             pc_addr,
  input  logic [CORE_WIDTH*32-1:0] instruction_blk,
  input  logic                    redirect_valid,
  input  logic [31:0]             redirect_pc,
  output logic                    fetch_valid,
  input  logic                    fetch_ready,
  output logic [CORE_WIDTH*32-1:0] fetch_instr,
  output logic [31:0]             fetch_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]             perf_fetched,
  output logic [31:0]             perf_stall_full
`endif
);

  localparam int          PW        = $clog2(FQ_DEPTH);
  localparam logic [31:0] PKT_BYTES = 32'(4 * CORE_WIDTH);
  localparam logic [PW:0] DEPTH_C   = (PW + 1)'(FQ_DEPTH);

  logic [31:0]             r_pc;
  logic [PW-1:0]           r_wr_ptr;
  logic [PW-1:0]           r_rd_ptr;
  logic [PW:0]             r_count;
  logic [31:0]             r_q_pc    [FQ_DEPTH];
  logic [CORE_WIDTH*32-1:0] r_q_instr [FQ_DEPTH];

  logic w_full;
  logic w_nonempty;
  logic w_deq;
  logic w_enq;

  assign w_full     = (r_count == DEPTH_C);
  assign w_nonempty = (r_count != '0);
  // A full queue may still accept when the head leaves in the same cycle.
  assign w_deq      = w_nonempty & fetch_ready & ~redirect_valid;
  assign w_enq      = ~redirect_valid & (~w_full | w_deq);

  assign pc_addr     = r_pc;
  assign fetch_valid = w_nonempty & ~redirect_valid;
  assign fetch_instr = r_q_instr[r_rd_ptr];
  assign fetch_pc    = r_q_pc[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_valid) begin
      r_pc     <= {redirect_pc[31:2], 2'b00};
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) begin
        r_pc     <= r_pc + PKT_BYTES;
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + (PW + 1)'(1);
        2'b01:   r_count <= r_count - (PW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry contents are only observed behind fetch_valid, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_q_pc[r_wr_ptr]    <= r_pc;
      r_q_instr[r_wr_ptr] <= instruction_blk;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetched    <= '0;
      r_perf_stall_full <= '0;
    end else begin
      if (w_enq) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (w_full & ~w_deq & ~redirect_valid) begin
        r_perf_stall_full <= r_perf_stall_full + 32'd1;
      end
    end
  end

  assign perf_fetched    = r_perf_fetched;
  assign perf_stall_full = r_perf_stall_full;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_addr;
  logic [63:0] instruction_blk;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [63:0] fetch_instr;
  logic [31:0] fetch_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall_full;
`endif

  fetch_unit #(.CORE_WIDTH(2), .RESET_PC(32'h0), .FQ_DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_addr        (pc_addr),
    .instruction_blk(instruction_blk),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .fetch_instr    (fetch_instr),
    .fetch_pc       (fetch_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall_full(perf_stall_full)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 128-word memory image; the top word holds a NOP, everything beyond is NOP.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    logic [31:0] idx;
    idx = addr >> 2;
    if (idx < 32'd127) return idx * 32'h1111_1111;
    return NOP;
  endfunction

  always_comb instruction_blk = {mem_word(pc_addr + 32'd4), mem_word(pc_addr)};

  int n_pass = 0;
  int n_total = 0;
  logic [31:0] sbq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic push_stream(input logic [31:0] base, input int n);
    sbq.delete();
    for (int i = 0; i < n; i++) sbq.push_back(base + 32'(8 * i));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted packet must be the next expected PC in order.
  always @(negedge clk) begin
    if (rst_n && fetch_valid && fetch_ready) begin
      logic [31:0] exp_pc;
      if (sbq.size() == 0) begin
        n_total++;
        $display("FAIL sb_underflow: got fetch_pc %h, expected no packet", fetch_pc);
      end else begin
        exp_pc = sbq.pop_front();
        check("sb_pc", {32'h0, fetch_pc}, {32'h0, exp_pc});
        check("sb_instr", fetch_instr, {mem_word(exp_pc + 32'd4), mem_word(exp_pc)});
      end
    end
  end

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] exp_pc;
    logic [31:0] lane0;
    logic [31:0] lane1;
  } redir_vec_t;

  redir_vec_t vecs[5];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{32'h0000_0106, 32'h0000_0104, 32'h5555_5551, 32'h6666_6662};
    vecs[1] = '{32'h0000_01F8, 32'h0000_01F8, 32'h6666_665E, NOP};
    vecs[2] = '{32'h0000_0003, 32'h0000_0000, 32'h0000_0000, 32'h1111_1111};
    vecs[3] = '{32'hFFFF_FFFB, 32'hFFFF_FFF8, NOP, NOP};
    vecs[4] = '{32'h0000_002C, 32'h0000_002C, 32'hBBBB_BBBB, 32'hCCCC_CCCC};

    rst_n = 1'b0;
    fetch_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    repeat (3) step();
    check("reset_valid", {63'h0, fetch_valid}, 64'h0);
    check("reset_pc_addr", {32'h0, pc_addr}, 64'h0);

    // Streaming from reset with decode always ready.
    push_stream(32'h0, 16);
    rst_n = 1'b1;
    check("release_pc_addr", {32'h0, pc_addr}, 64'h0);
    step();
    check("first_valid", {63'h0, fetch_valid}, 64'h1);
    check("first_pc", {32'h0, fetch_pc}, 64'h0);
    check("first_pc_addr", {32'h0, pc_addr}, 64'h8);
    repeat (6) step();

    // Decode stalls: queue fills, PC freezes, head holds.
    rst_n = 1'b0;
    #1;
    push_stream(32'h0, 16);
    fetch_ready = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (6) step();
    check("stall_pc_addr", {32'h0, pc_addr}, 64'd32);
    check("stall_head_pc", {32'h0, fetch_pc}, 64'h0);
    check("stall_valid", {63'h0, fetch_valid}, 64'h1);
    fetch_ready = 1'b1;
    step();
    check("full_thru_pc_addr0", {32'h0, pc_addr}, 64'd40);
    step();
    check("full_thru_pc_addr1", {32'h0, pc_addr}, 64'd48);
    check("full_thru_valid", {63'h0, fetch_valid}, 64'h1);
    repeat (4) step();

    // Redirect vectors.
    for (int v = 0; v < 5; v++) begin
      redirect_valid = 1'b1;
      redirect_pc = vecs[v].rpc;
      push_stream(vecs[v].exp_pc, 16);
      #1;
      check($sformatf("redir%0d_mask", v), {63'h0, fetch_valid}, 64'h0);
      step();
      redirect_valid = 1'b0;
      #1;
      check($sformatf("redir%0d_pc_addr", v), {32'h0, pc_addr}, {32'h0, vecs[v].exp_pc});
      check($sformatf("redir%0d_empty", v), {63'h0, fetch_valid}, 64'h0);
      step();
      check($sformatf("redir%0d_valid", v), {63'h0, fetch_valid}, 64'h1);
      check($sformatf("redir%0d_pc", v), {32'h0, fetch_pc}, {32'h0, vecs[v].exp_pc});
      check($sformatf("redir%0d_instr", v), fetch_instr, {vecs[v].lane1, vecs[v].lane0});
      repeat (3) step();
    end

    // Back-to-back redirects: the second one wins.
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0040;
    push_stream(32'h40, 16);
    step();
    redirect_pc = 32'h0000_0081;
    push_stream(32'h80, 16);
    #1;
    check("b2b_mask", {63'h0, fetch_valid}, 64'h0);
    step();
    redirect_valid = 1'b0;
    #1;
    check("b2b_pc_addr", {32'h0, pc_addr}, 64'h80);
    repeat (4) step();

    // Asynchronous reset with three packets queued.
    rst_n = 1'b0;
    #1;
    push_stream(32'h0, 16);
    fetch_ready = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (3) step();
    check("pre_rst_valid", {63'h0, fetch_valid}, 64'h1);
    check("pre_rst_pc_addr", {32'h0, pc_addr}, 64'd24);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched_3", {32'h0, perf_fetched}, 64'd3);
    check("perf_stall_0", {32'h0, perf_stall_full}, 64'd0);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {63'h0, fetch_valid}, 64'h0);
    check("async_rst_pc_addr", {32'h0, pc_addr}, 64'h0);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched_clr", {32'h0, perf_fetched}, 64'd0);
`endif
    repeat (2) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
